// File: rtl/xif_copro_exec_if.sv
// xif_copro_pkg / xif_copro_exec_if
// Purpose : decoder output type shared with the coprocessor decoder, plus the
//           bundle of handshake/data signals between the decoder side and the
//           xif_copro_exec stage.
// Ports   : master modport = upstream/downstream environment (drives the
//           instruction, kill request and result ready);
//           slave modport  = xif_copro_exec (drives ready, result and tags).
//           in_valid_i/in_ready_o/decoder_i/operand_a_i/rd_i/id_i : instruction in
//           kill_i/kill_id_i                                       : kill request
//           out_valid_o/out_ready_i/result_o/rd_o/id_o/we_o        : writeback out

package xif_copro_pkg;

  typedef enum logic [1:0] {
    OpNone   = 2'd0,
    OpBitrev = 2'd1
  } op_e;

  typedef struct packed {
    logic use_copro;
    op_e  op;
  } decoder_t;

endpackage

interface xif_copro_exec_if #(
  parameter int unsigned ID_WIDTH = 4
);

  logic                     in_valid_i;
  logic                     in_ready_o;
  xif_copro_pkg::decoder_t  decoder_i;
  logic [31:0]              operand_a_i;
  logic [4:0]               rd_i;
  logic [ID_WIDTH-1:0]      id_i;
  logic                     kill_i;
  logic [ID_WIDTH-1:0]      kill_id_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [31:0]              result_o;
  logic [4:0]               rd_o;
  logic [ID_WIDTH-1:0]      id_o;
  logic                     we_o;

  modport master (
    output in_valid_i, decoder_i, operand_a_i, rd_i, id_i, kill_i, kill_id_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, rd_o, id_o, we_o
  );

  modport slave (
    input  in_valid_i, decoder_i, operand_a_i, rd_i, id_i, kill_i, kill_id_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, rd_o, id_o, we_o
  );

endinterface

// File: rtl/xif_copro_exec.sv
// xif_copro_exec
// Purpose : execution stage behind the XIF coprocessor decoder. Accepts one decoded
//           instruction, executes it (BITREV iteratively, BITS_PER_CYCLE bits per
//           cycle) and holds a single writeback result until it is taken. In-flight
//           instructions can be killed by id.
// Ports   : clk_i  clock, rising edge
//           rst_i  asynchronous reset, active-high
//           bus    xif_copro_exec_if.slave (instruction in, kill, result out)
//           perf_cnt_o [31:0] count of accepted results with we_o=1
//                      (present only when XIF_COPRO_EXEC_PERF_CNT_EN is defined)
// Build   : `define XIF_COPRO_EXEC_PERF_CNT_EN to add the performance counter.

module xif_copro_exec #(
  parameter int          BITS_PER_CYCLE = 8,
  parameter int unsigned ID_WIDTH       = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef XIF_COPRO_EXEC_PERF_CNT_EN
  output logic [31:0]          perf_cnt_o,
`endif
  xif_copro_exec_if.slave      bus
);

  localparam int B = BITS_PER_CYCLE;
  localparam int STEPS = 32 / ((B > 0) ? B : 1);
  localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

  // Must match xif_copro_pkg::OpBitrev
  localparam logic [1:0] OP_BITREV = 2'd1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (!(B == 1 || B == 2 || B == 4 || B == 8 || B == 16 || B == 32)) begin : g_bad_param
    $error("xif_copro_exec: BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
  end

  logic [1:0]          r_state;
  logic [31:0]         r_src;
  logic [31:0]         r_acc;
  logic [5:0]          r_cnt;
  logic [31:0]         r_result;
  logic [4:0]          r_rd;
  logic [ID_WIDTH-1:0] r_id;
  logic                r_we;

  logic [B-1:0]        w_rev;
  logic [31:0]         w_acc_next;
  logic                w_accept;
  logic                w_kill_held;
  logic                w_kill_new;
  logic                w_is_bitrev;
  logic                w_out_hs;

  always_comb begin
    w_rev = '0;
    for (int j = 0; j < B; j++) begin
      w_rev[j] = r_src[B-1-j];
    end
  end

  // Reversed chunks enter at the bottom, so the first chunk ends up at the top.
  if (B == 32) begin : g_acc_full
    assign w_acc_next = w_rev;
  end else begin : g_acc_shift
    assign w_acc_next = {r_acc[31-B:0], w_rev};
  end

  assign w_accept    = bus.in_valid_i & (r_state == ST_IDLE);
  assign w_kill_held = bus.kill_i & (r_state != ST_IDLE) & (bus.kill_id_i == r_id);
  // A kill arriving with the instruction itself is matched against the incoming id.
  assign w_kill_new  = bus.kill_i & w_accept & (bus.kill_id_i == bus.id_i);
  assign w_is_bitrev = bus.decoder_i.use_copro & (bus.decoder_i.op == OP_BITREV);
  assign w_out_hs    = (r_state == ST_DONE) & bus.out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_src    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_rd     <= '0;
      r_id     <= '0;
      r_we     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !w_kill_new) begin
            r_src <= bus.operand_a_i;
            r_acc <= '0;
            r_cnt <= '0;
            r_rd  <= bus.rd_i;
            r_id  <= bus.id_i;
            if (w_is_bitrev) begin
              r_state <= ST_BUSY;
              r_we    <= 1'b1;
            end else begin
              r_state  <= ST_DONE;
              r_result <= '0;
              r_we     <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          if (w_kill_held) begin
            r_state <= ST_IDLE;
          end else begin
            r_src <= r_src >> B;
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == LAST_STEP) begin
              r_state  <= ST_DONE;
              r_result <= w_acc_next;
            end
          end
        end
        ST_DONE: begin
          if (w_kill_held || w_out_hs) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef XIF_COPRO_EXEC_PERF_CNT_EN
  logic [31:0] r_perf_cnt;

  // A kill in the handshake cycle drops the result, so it is not counted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_cnt <= '0;
    end else if (w_out_hs && !w_kill_held && r_we) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign perf_cnt_o = r_perf_cnt;
`endif

  assign bus.in_ready_o  = (r_state == ST_IDLE);
  assign bus.out_valid_o = (r_state == ST_DONE);
  assign bus.result_o    = r_result;
  assign bus.rd_o        = r_rd;
  assign bus.id_o        = r_id;
  assign bus.we_o        = r_we;

endmodule
